// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file for the pipelined CPU.
// Two combinational read ports with optional same-cycle write forwarding,
// two write ports (ALU writeback and load return, load return wins on a
// collision), a per-register busy scoreboard for hazard detection, and a
// registered debug read port for the board display.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_A,
    input  logic [ADDR_W-1:0] raddr_B,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we2,
    input  logic [ADDR_W-1:0] waddr2,
    input  logic [DATA_W-1:0] wdata2,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] set_addr,
    output logic              busy_A,
    output logic              busy_B,
    input  logic [ADDR_W-1:0] which_reg,
    output logic [DATA_W-1:0] reg_content
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;
    logic [DATA_W-1:0] arr_dbg;
    logic              bit_a;
    logic              bit_b;

    logic hit1_a, hit2_a, hit1_b, hit2_b;
    logic set_a, set_b;

    // An address is live only if it is implemented and is not the hardwired zero register.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    // Decode the three read addresses against the implemented registers; unimplemented addresses fall through to 0.
    always_comb begin
        arr_a   = '0;
        arr_b   = '0;
        arr_dbg = '0;
        bit_a   = 1'b0;
        bit_b   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_A == ADDR_W'(i)) begin
                arr_a = regs[i];
                bit_a = busy[i];
            end
            if (raddr_B == ADDR_W'(i)) begin
                arr_b = regs[i];
                bit_b = busy[i];
            end
            if (which_reg == ADDR_W'(i)) begin
                arr_dbg = regs[i];
            end
        end
    end

    // Same-cycle write matches used for forwarding and for suppressing stale busy bits.
    always_comb begin
        hit1_a = BYPASS && we  && (waddr  == raddr_A) && writable(waddr);
        hit2_a = BYPASS && we2 && (waddr2 == raddr_A) && writable(waddr2);
        hit1_b = BYPASS && we  && (waddr  == raddr_B) && writable(waddr);
        hit2_b = BYPASS && we2 && (waddr2 == raddr_B) && writable(waddr2);
        set_a  = set_busy && (set_addr == raddr_A);
        set_b  = set_busy && (set_addr == raddr_B);
    end

    // Read port data: zero in reset or for dead addresses, else forwarded write data (port 2 first), else the array.
    always_comb begin
        rdata_A = '0;
        rdata_B = '0;
        if (!rst) begin
            if (writable(raddr_A)) begin
                if (hit2_a)      rdata_A = wdata2;
                else if (hit1_a) rdata_A = wdata;
                else             rdata_A = arr_a;
            end
            if (writable(raddr_B)) begin
                if (hit2_b)      rdata_B = wdata2;
                else if (hit1_b) rdata_B = wdata;
                else             rdata_B = arr_b;
            end
        end
    end

    // Busy outputs: a register being written this cycle is already resolved, unless a new producer is issued to it.
    always_comb begin
        busy_A = 1'b0;
        busy_B = 1'b0;
        if (!rst) begin
            if (writable(raddr_A) && !((hit1_a || hit2_a) && !set_a)) busy_A = bit_a;
            if (writable(raddr_B) && !((hit1_b || hit2_b) && !set_b)) busy_B = bit_b;
        end
    end

    // Array, scoreboard and debug register update; later assignments take priority (port 2 over port 1, set over clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            regs        <= '{default: '0};
            busy        <= '0;
            reg_content <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!(ZERO_REG && (i == 0))) begin
                    if (we && (waddr == ADDR_W'(i)))
                        regs[i] <= wdata;
                    if (we2 && (waddr2 == ADDR_W'(i)))
                        regs[i] <= wdata2;
                    if ((we && (waddr == ADDR_W'(i))) || (we2 && (waddr2 == ADDR_W'(i))))
                        busy[i] <= 1'b0;
                    if (set_busy && (set_addr == ADDR_W'(i)))
                        busy[i] <= 1'b1;
                end
            end
            reg_content <= writable(which_reg) ? arr_dbg : '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp with an array-based reference
// model checked every cycle, on a forwarding instance and a non-forwarding one.
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] raddr_A, raddr_B, waddr, waddr2, set_addr, which_reg;
    logic [DATA_W-1:0] wdata, wdata2;
    logic              we, we2, set_busy;

    logic [DATA_W-1:0] rdata_A, rdata_B, reg_content;
    logic              busy_A, busy_B;
    logic [DATA_W-1:0] nb_rdata_A, nb_rdata_B, nb_reg_content;
    logic              nb_busy_A, nb_busy_B;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                 .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .raddr_A(raddr_A), .raddr_B(raddr_B),
        .rdata_A(rdata_A), .rdata_B(rdata_B),
        .we(we), .waddr(waddr), .wdata(wdata),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy_A(busy_A), .busy_B(busy_B),
        .which_reg(which_reg), .reg_content(reg_content)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                 .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .raddr_A(raddr_A), .raddr_B(raddr_B),
        .rdata_A(nb_rdata_A), .rdata_B(nb_rdata_B),
        .we(we), .waddr(waddr), .wdata(wdata),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy_A(nb_busy_A), .busy_B(nb_busy_B),
        .which_reg(which_reg), .reg_content(nb_reg_content)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: plain arrays of register values and pending flags.
    logic [DATA_W-1:0] mregs [NUM_REGS];
    logic              mbusy [NUM_REGS];
    logic [DATA_W-1:0] exp_dbg;
    logic              model_live = 1'b0;

    function automatic bit live_addr(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && (a != 0);
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a, input bit byp);
        if (rst || !live_addr(a)) return '0;
        if (byp && we2 && waddr2 == a) return wdata2;
        if (byp && we && waddr == a) return wdata;
        return mregs[int'(a)];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a, input bit byp);
        if (rst || !live_addr(a)) return 1'b0;
        if (byp && ((we && waddr == a) || (we2 && waddr2 == a)) && !(set_busy && set_addr == a))
            return 1'b0;
        return mbusy[int'(a)];
    endfunction

    // Model update on each rising edge: debug snapshot of the old value, then writes, then busy set/clear.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mregs[i] <= '0;
                mbusy[i] <= 1'b0;
            end
            exp_dbg    <= '0;
            model_live <= 1'b1;
        end else begin
            exp_dbg <= live_addr(which_reg) ? mregs[int'(which_reg)] : '0;
            if (we && live_addr(waddr)) begin
                mregs[int'(waddr)] <= wdata;
                mbusy[int'(waddr)] <= 1'b0;
            end
            if (we2 && live_addr(waddr2)) begin
                mregs[int'(waddr2)] <= wdata2;
                mbusy[int'(waddr2)] <= 1'b0;
            end
            if (set_busy && live_addr(set_addr))
                mbusy[int'(set_addr)] <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge after the first reset, compare both instances against the model.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("model_rdata_A",    rdata_A,            exp_rd(raddr_A, 1'b1));
            checkOutput("model_rdata_B",    rdata_B,            exp_rd(raddr_B, 1'b1));
            checkOutput("model_busy_A",     32'(busy_A),        32'(exp_busy(raddr_A, 1'b1)));
            checkOutput("model_busy_B",     32'(busy_B),        32'(exp_busy(raddr_B, 1'b1)));
            checkOutput("model_dbg",        reg_content,        exp_dbg);
            checkOutput("model_nb_rdata_A", nb_rdata_A,         exp_rd(raddr_A, 1'b0));
            checkOutput("model_nb_rdata_B", nb_rdata_B,         exp_rd(raddr_B, 1'b0));
            checkOutput("model_nb_busy_A",  32'(nb_busy_A),     32'(exp_busy(raddr_A, 1'b0)));
            checkOutput("model_nb_busy_B",  32'(nb_busy_B),     32'(exp_busy(raddr_B, 1'b0)));
            checkOutput("model_nb_dbg",     nb_reg_content,     exp_dbg);
        end
    end

    task automatic applyStimulus(input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                 input logic w2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2,
                                 input logic sb, input logic [ADDR_W-1:0] sa,
                                 input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                                 input logic [ADDR_W-1:0] dbg);
        we = w1;  waddr = a1;  wdata = d1;
        we2 = w2; waddr2 = a2; wdata2 = d2;
        set_busy = sb; set_addr = sa;
        raddr_A = ra; raddr_B = rb; which_reg = dbg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        // Preload r3 = 5, then reset for two cycles while reading r3
        applyStimulus(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3);
        mid();
        checkOutput("r3_preload", rdata_A, 32'd5);
        step();
        rst = 1'b1;
        mid();
        checkOutput("rst_rdata_A", rdata_A, 32'd0);
        checkOutput("rst_busy_A", 32'(busy_A), 32'd0);
        step();
        step();
        rst = 1'b0;
        mid();
        checkOutput("post_rst_rdata_A", rdata_A, 32'd0);
        checkOutput("post_rst_dbg", reg_content, 32'd0);
        step();

        // Write r4 with same-cycle read: forwarded vs. old value
        applyStimulus(1, 4, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4, 0, 0);
        mid();
        checkOutput("bypass_rdata_A", rdata_A, 32'hDEADBEEF);
        checkOutput("nobypass_old", nb_rdata_A, 32'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        mid();
        checkOutput("nobypass_new", nb_rdata_A, 32'hDEADBEEF);
        step();

        // Both write ports target r7: port 2 wins
        applyStimulus(1, 7, 32'd1, 1, 7, 32'd2, 0, 0, 0, 7, 0);
        mid();
        checkOutput("dual_bypass_B", rdata_B, 32'd2);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        mid();
        checkOutput("dual_r7", rdata_B, 32'd2);
        checkOutput("dual_r7_nb", nb_rdata_B, 32'd2);
        step();

        // Writes and busy-set to r0 and the unimplemented r20 are ignored
        applyStimulus(1, 0, 32'h55, 1, 20, 32'h55, 1, 0, 0, 20, 0);
        mid();
        checkOutput("zero_rdata_A", rdata_A, 32'd0);
        checkOutput("oor_rdata_B", rdata_B, 32'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 20);
        mid();
        checkOutput("zero_busy_A", 32'(busy_A), 32'd0);
        checkOutput("zero_after_A", rdata_A, 32'd0);
        step();
        mid();
        checkOutput("oor_dbg", reg_content, 32'd0);
        step();

        // Scoreboard: set r9, clear by load return, then set and write together
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
        mid();
        checkOutput("sb_set", 32'(busy_A), 32'd1);
        step();
        applyStimulus(0, 0, 0, 1, 9, 32'h10, 0, 0, 9, 0, 0);
        mid();
        checkOutput("sb_bypass_clear", 32'(busy_A), 32'd0);
        checkOutput("sb_bypass_data", rdata_A, 32'h10);
        checkOutput("sb_nb_still_busy", 32'(nb_busy_A), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
        mid();
        checkOutput("sb_cleared", 32'(busy_A), 32'd0);
        checkOutput("sb_r9", rdata_A, 32'h10);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        step();
        applyStimulus(1, 9, 32'h20, 0, 0, 0, 1, 9, 9, 0, 0);
        mid();
        checkOutput("sb_set_and_write", 32'(busy_A), 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
        mid();
        checkOutput("sb_stays", 32'(busy_A), 32'd1);
        checkOutput("sb_r9_new", rdata_A, 32'h20);
        step();

        // Debug latency: select r4 while writing it
        applyStimulus(1, 4, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 4);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        mid();
        checkOutput("dbg_old_r4", reg_content, 32'hDEADBEEF);
        step();
        mid();
        checkOutput("dbg_new_r4", reg_content, 32'h1234);
        step();

        // Mixed traffic over implemented and unimplemented addresses, checked by the model
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 19)), $urandom,
                          1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 19)), $urandom,
                          1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 19)),
                          ADDR_W'($urandom_range(0, 19)), ADDR_W'($urandom_range(0, 19)),
                          ADDR_W'($urandom_range(0, 31)));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
